// File: rtl/prio_dec_pkg.sv
// Shared types, widths and the code-to-pattern decode used by the priority demux.
package prio_dec_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CODE_W = $clog2(DATA_W);
  localparam int unsigned N_CH   = 4;
  localparam int unsigned SEL_W  = $clog2(N_CH);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBuild = 2'd1,
    StFull  = 2'd2
  } chan_state_e;

  // Mask mode sets bits code..0, i.e. (2 << code) - 1 evaluated one bit wider than the word.
  function automatic logic [DATA_W-1:0] decode(input logic [CODE_W-1:0] code,
                                               input logic              zero,
                                               input logic              mask_mode);
    logic [DATA_W:0] w_bit;
    logic [DATA_W:0] w_mask;
    w_bit  = {{DATA_W{1'b0}}, 1'b1} << code;
    w_mask = (w_bit << 1) - {{DATA_W{1'b0}}, 1'b1};
    if (zero) begin
      return '0;
    end
    if (mask_mode) begin
      return w_mask[DATA_W-1:0];
    end
    return w_bit[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/prio_dec_chan.sv
// One output channel: accumulates decoded beats into a word and holds it until drained.
module prio_dec_chan
  import prio_dec_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_acc,
  input  logic [DATA_W-1:0] i_dec,
  input  logic              i_last,
  input  logic              i_out_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_busy
);

  chan_state_e       r_state;
  chan_state_e       w_state_nxt;
  chan_state_e       w_fill_state;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;

  assign w_fill_state = i_last ? StFull : StBuild;

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    unique case (r_state)
      StEmpty: begin
        if (i_acc) begin
          w_data_nxt  = i_dec;
          w_state_nxt = w_fill_state;
        end
      end
      StBuild: begin
        if (i_acc) begin
          w_data_nxt  = r_data | i_dec;
          w_state_nxt = w_fill_state;
        end
      end
      StFull: begin
        // A drain and a new first beat in the same cycle start a fresh word.
        if (i_out_ready) begin
          if (i_acc) begin
            w_data_nxt  = i_dec;
            w_state_nxt = w_fill_state;
          end else begin
            w_state_nxt = StEmpty;
          end
        end
      end
      default: w_state_nxt = StEmpty;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StEmpty;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign o_full  = (r_state == StFull);
  assign o_valid = o_full;
  assign o_busy  = (r_state != StEmpty);
  assign o_data  = r_data;

endmodule

// File: rtl/prio_dec_demux1to4.sv
// Priority-code demux: decodes tagged codes and assembles one word per output channel.
module prio_dec_demux1to4
  import prio_dec_pkg::*;
#(
  parameter int unsigned DEC_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CODE_W-1:0]        in_code,
  input  logic                     in_zero,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_last,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic                     busy
);

  localparam logic MaskMode = (DEC_MODE != 0);

  logic [DATA_W-1:0] w_dec;
  logic              w_fire;
  logic [N_CH-1:0]   w_full;
  logic [N_CH-1:0]   w_busy;

  assign w_dec = decode(in_code, in_zero, MaskMode);

  // Only the addressed channel can stall the input; others keep flowing.
  assign in_ready = ~w_full[in_sel] | out_ready[in_sel];
  assign w_fire   = in_valid & in_ready;
  assign busy     = |w_busy;

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    logic w_acc;
    assign w_acc = w_fire & (in_sel == SEL_W'(k));

    prio_dec_chan u_chan (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_acc       (w_acc),
      .i_dec       (w_dec),
      .i_last      (in_last),
      .i_out_ready (out_ready[k]),
      .o_valid     (out_valid[k]),
      .o_data      (out_data[k*DATA_W +: DATA_W]),
      .o_full      (w_full[k]),
      .o_busy      (w_busy[k])
    );
  end

endmodule
